ddr2_rd_data_lanes: RTL and testbench
=====================================

// Module: ddr2_rd_data_lanes
// PURPOSE
//  Parametrised read-data return path between the DQ capture/calibration lanes and the user read port.
//  - Per-lane skew FIFOs pair each lane's rise/fall beats and re-align the lanes into one full-width word.
//  - Adds valid/ready back-pressure, overflow detection and flush.
//  - Aggregates per-lane calibration status (done, error, first-loop) for the controller.
// PARAMETERS
//  NUM_LANES   4   DQS strobe groups (lanes), >=1
//  LANE_WIDTH  8   DQ bits per lane
//  FIFO_DEPTH  8   entries per lane FIFO, power of 2, >=2
// PORTS
//  clk                  in   1            memory-side clock
//  reset                in   1            async active-low reset
//  flush                in   1            sync clear of FIFOs, staging regs and overflow
//  read_data_rise       in   NUM_LANES*LANE_WIDTH   captured rising-edge DQ
//  read_data_fall       in   NUM_LANES*LANE_WIDTH   captured falling-edge DQ
//  lane_rise_en         in   NUM_LANES    per-lane rise beat valid (calibrated rd enable)
//  lane_fall_en         in   NUM_LANES    per-lane fall beat valid
//  lane_first_rising    in   NUM_LANES    1: lane's fall beat arrives one cycle after its rise beat
//  lane_comp_done       in   NUM_LANES    per-lane pattern calibration done
//  lane_comp_error      in   NUM_LANES    per-lane pattern calibration error
//  lane_cal_first_loop  in   NUM_LANES    per-lane first-loop flag
//  rd_ready             in   1            user accepts word
//  rd_valid             out  1            aligned word available
//  rd_data_rise         out  NUM_LANES*LANE_WIDTH
//  rd_data_fall         out  NUM_LANES*LANE_WIDTH
//  comp_done            out  1            registered AND of lane_comp_done
//  comp_error           out  1            sticky OR of lane_comp_error
//  cal_first_loop       out  1            low pulse requesting second calibration read
//  overflow             out  1            sticky: a push into a full lane FIFO was dropped
//  dbg_lane_level       out  NUM_LANES*$clog2(FIFO_DEPTH+1)   per-lane occupancy
// BEHAVIOUR
//  - Interface: one clock; reset is asynchronous and active-low.
//  - Reset values: all FIFOs empty, rd_valid=0, rd_data_*=0, comp_done=0, comp_error=0, cal_first_loop=1,
//    overflow=0, staging regs empty.
//  - Lane pairing, first_rising=0: on lane_rise_en, push {rise,fall} from the same cycle; lane_fall_en is ignored.
//  - Lane pairing, first_rising=1: on lane_rise_en, hold the rise slice in the staging reg.
//    On the next lane_fall_en, push {staged rise, current fall}.
//    A second rise_en arriving before fall_en overwrites the staging reg.
//    fall_en with the staging reg empty is ignored.
//  - lane_first_rising is sampled per beat; changing it with the staging reg full discards the staged rise.
//  - Alignment: rd_valid=1 iff every lane FIFO is non-empty.
//    rd_data_* is the head entry of each lane, concatenated lane0 at LSB.
//  - Handshake: pop all lanes when rd_valid & rd_ready.
//    rd_data_* holds stable while rd_valid & !rd_ready.
//  - Latency: a push completing the last lane gives rd_valid on the next cycle; there is no same-cycle bypass.
//  - Full lane: a push with no pop that cycle is dropped, overflow<=1, and other lanes are unaffected.
//    Simultaneous push+pop on a full lane succeeds and the level is unchanged.
//  - Empty lane: a pop cannot occur because rd_valid=0.
//  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally; the level counter saturates 0..FIFO_DEPTH.
//  - flush: next cycle all levels=0, staging regs empty, rd_valid=0, overflow=0.
//    Pushes in the flush cycle are discarded. flush has priority over push/pop.
//  - Calibration flags:
//    - comp_done <= &lane_comp_done.
//    - comp_error <= comp_error | (|lane_comp_error); cleared only by reset.
//    - lane_cal_first_loop is registered to lcfl_r.
//    - cal_first_loop <= 0 for one cycle when (lcfl_r != lane_cal_first_loop) && !(&lane_cal_first_loop);
//      otherwise 1.
//  - Reset mid-burst: all state clears immediately; in-flight beats are lost; no partial word is ever presented.
// STRUCTURE
//  - Shared package ddr2_rd_pkg: NUM_LANES/LANE_WIDTH/FIFO_DEPTH defaults, derived PTR_W and LVL_W, and the
//    lane-entry struct {rise,fall}.
//  - Sub-module ddr2_rd_lane_fifo: one per lane via generate. It owns the staging reg, pairing logic,
//    the FIFO RAM, pointers and the level counter.
//    Ports: push_rise_en, push_fall_en, first_rising, flush, pop, head, empty, full, drop, level.
//  - Top: all-lanes-non-empty AND, common pop, overflow OR-reduction and sticky reg, calibration flag logic.
// TESTING
//  1. Reset, then NUM_LANES=4, first_rising=0, all rise_en pulse together with rise=0x0403_0201,
//     fall=0x0807_0605 -> rd_valid=1 next cycle with the same data; rd_ready=1 pops and rd_valid=0 after.
//  2. Lane skew: lanes 0-1 push at T, lanes 2-3 push at T+2 -> rd_valid=0 through T+2 and 1 at T+3;
//     the word is assembled correctly.
//  3. first_rising=1 on lane 1: rise_en at T (0xAA), fall_en at T+1 (0x55) -> lane 1 entry {0xAA,0x55};
//     fall_en without a prior rise is dropped (level unchanged).
//  4. rd_ready=0, push FIFO_DEPTH+1 words into all lanes -> levels=8, overflow=1 after the 9th push,
//     first 8 words drain in order.
//     Then assert flush -> levels=0, overflow=0.
//  5. Full + simultaneous push/pop with rd_ready=1 -> level stays 8, no overflow, order preserved.
//  6. lane_cal_first_loop 1111->1101 -> cal_first_loop low exactly one cycle.
//     lane_comp_done=1111 -> comp_done=1 next cycle.
//     Pulse lane_comp_error[2] -> comp_error stays 1.
//     Assert reset mid-burst -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ddr2_rd_pkg.sv
// Shared defaults and types for the DDR2 read-data return path.
package ddr2_rd_pkg;

  localparam int DEF_NUM_LANES  = 4;
  localparam int DEF_LANE_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 8;

  localparam int PTR_W = $clog2(DEF_FIFO_DEPTH);
  localparam int LVL_W = $clog2(DEF_FIFO_DEPTH + 1);

  // One lane FIFO entry: the rise beat and the fall beat it was paired with.
  typedef struct packed {
    logic [DEF_LANE_WIDTH-1:0] rise;
    logic [DEF_LANE_WIDTH-1:0] fall;
  } lane_entry_t;

endpackage

// File: rtl/ddr2_rd_lane_fifo.sv
// One lane of the read return path: pairs rise/fall beats (optionally
// across two cycles through a staging register) and queues the pairs
// in a small skew FIFO until every lane has data.
module ddr2_rd_lane_fifo
  import ddr2_rd_pkg::*;
#(
  parameter int WIDTH = DEF_LANE_WIDTH,
  parameter int DEPTH = DEF_FIFO_DEPTH,
  localparam int PW   = $clog2(DEPTH),
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push_rise_en,
  input  logic             push_fall_en,
  input  logic             first_rising,
  input  logic [WIDTH-1:0] rise_in,
  input  logic [WIDTH-1:0] fall_in,
  input  logic             pop,
  output logic [2*WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic             drop,
  output logic [LW-1:0]    level
);

  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic               staged_valid_q, staged_valid_d;
  logic [WIDTH-1:0]   staged_rise_q, staged_rise_d;
  logic               push_req, push_ok;
  logic [2*WIDTH-1:0] push_data;

  // Beat pairing: same-cycle pairs, or a staged rise joined by the next fall.
  // Leaving first_rising mode always discards whatever rise was staged.
  always_comb begin
    push_req       = 1'b0;
    push_data      = {rise_in, fall_in};
    staged_valid_d = 1'b0;
    staged_rise_d  = staged_rise_q;
    if (!first_rising) begin
      push_req = push_rise_en;
    end else begin
      staged_valid_d = staged_valid_q;
      if (push_fall_en && staged_valid_q) begin
        push_req       = 1'b1;
        push_data      = {staged_rise_q, fall_in};
        staged_valid_d = 1'b0;
      end
      if (push_rise_en) begin
        staged_valid_d = 1'b1;
        staged_rise_d  = rise_in;
      end
    end
    if (flush) begin
      push_req       = 1'b0;
      staged_valid_d = 1'b0;
    end
  end

  // FIFO bookkeeping: a push into a full lane only lands if a pop frees a slot.
  always_comb begin
    empty    = (level_q == '0);
    full     = (level_q == LW'(DEPTH));
    push_ok  = push_req && (!full || pop);
    drop     = push_req && full && !pop;
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
    head  = mem_q[rd_ptr_q];
    level = level_q;
  end

  // Control state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      staged_valid_q <= 1'b0;
      staged_rise_q  <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      staged_valid_q <= staged_valid_d;
      staged_rise_q  <= staged_rise_d;
    end
  end

  // Entry storage; contents are only observed through a non-empty head.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ddr2_rd_data_lanes.sv
// Read-data return path: per-lane skew FIFOs re-aligned into one word
// with valid/ready, sticky overflow, flush, and calibration status roll-up.
module ddr2_rd_data_lanes
  import ddr2_rd_pkg::*;
#(
  parameter int NUM_LANES  = DEF_NUM_LANES,
  parameter int LANE_WIDTH = DEF_LANE_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int LB        = $clog2(FIFO_DEPTH + 1),
  localparam int DW        = NUM_LANES * LANE_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [DW-1:0]        read_data_rise,
  input  logic [DW-1:0]        read_data_fall,
  input  logic [NUM_LANES-1:0] lane_rise_en,
  input  logic [NUM_LANES-1:0] lane_fall_en,
  input  logic [NUM_LANES-1:0] lane_first_rising,
  input  logic [NUM_LANES-1:0] lane_comp_done,
  input  logic [NUM_LANES-1:0] lane_comp_error,
  input  logic [NUM_LANES-1:0] lane_cal_first_loop,
  input  logic                 rd_ready,
  output logic                 rd_valid,
  output logic [DW-1:0]        rd_data_rise,
  output logic [DW-1:0]        rd_data_fall,
  output logic                 comp_done,
  output logic                 comp_error,
  output logic                 cal_first_loop,
  output logic                 overflow,
  output logic [NUM_LANES*LB-1:0] dbg_lane_level
);

  logic [NUM_LANES-1:0]    lane_empty, lane_full, lane_drop;
  logic [2*LANE_WIDTH-1:0] lane_head [NUM_LANES];
  logic                    pop;

  logic                 overflow_q, overflow_d;
  logic                 comp_done_q, comp_done_d;
  logic                 comp_error_q, comp_error_d;
  logic                 cal_first_loop_q, cal_first_loop_d;
  logic [NUM_LANES-1:0] lcfl_q;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    ddr2_rd_lane_fifo #(
      .WIDTH (LANE_WIDTH),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .push_rise_en (lane_rise_en[g]),
      .push_fall_en (lane_fall_en[g]),
      .first_rising (lane_first_rising[g]),
      .rise_in      (read_data_rise[g*LANE_WIDTH +: LANE_WIDTH]),
      .fall_in      (read_data_fall[g*LANE_WIDTH +: LANE_WIDTH]),
      .pop          (pop),
      .head         (lane_head[g]),
      .empty        (lane_empty[g]),
      .full         (lane_full[g]),
      .drop         (lane_drop[g]),
      .level        (dbg_lane_level[g*LB +: LB])
    );
  end

  // A word exists only when every lane holds an entry; all lanes pop together.
  // Data is forced to zero while no word is available so no partial word leaks out.
  always_comb begin
    rd_valid     = &(~lane_empty);
    pop          = rd_valid && rd_ready;
    rd_data_rise = '0;
    rd_data_fall = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (rd_valid) begin
        rd_data_rise[i*LANE_WIDTH +: LANE_WIDTH] = lane_head[i][2*LANE_WIDTH-1:LANE_WIDTH];
        rd_data_fall[i*LANE_WIDTH +: LANE_WIDTH] = lane_head[i][LANE_WIDTH-1:0];
      end
    end
  end

  // Sticky overflow and calibration status next-state.
  always_comb begin
    overflow_d       = flush ? 1'b0 : (overflow_q | (|(lane_drop & lane_full)));
    comp_done_d      = &lane_comp_done;
    comp_error_d     = comp_error_q | (|lane_comp_error);
    cal_first_loop_d = !((lcfl_q != lane_cal_first_loop) && !(&lane_cal_first_loop));
  end

  // Status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q       <= 1'b0;
      comp_done_q      <= 1'b0;
      comp_error_q     <= 1'b0;
      cal_first_loop_q <= 1'b1;
      lcfl_q           <= '1;
    end else begin
      overflow_q       <= overflow_d;
      comp_done_q      <= comp_done_d;
      comp_error_q     <= comp_error_d;
      cal_first_loop_q <= cal_first_loop_d;
      lcfl_q           <= lane_cal_first_loop;
    end
  end

  assign overflow       = overflow_q;
  assign comp_done      = comp_done_q;
  assign comp_error     = comp_error_q;
  assign cal_first_loop = cal_first_loop_q;

endmodule

// File: tb/tb_ddr2_rd_data_lanes.sv
// Self-checking bench for ddr2_rd_data_lanes: directed scenarios plus a
// randomized phase, all compared against a queue-based lane model.
module tb_ddr2_rd_data_lanes;
  import ddr2_rd_pkg::*;

  localparam int NL = 4;
  localparam int W  = 8;
  localparam int D  = 8;
  localparam int LB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic [31:0]   read_data_rise = '0, read_data_fall = '0;
  logic [NL-1:0] lane_rise_en = '0, lane_fall_en = '0, lane_first_rising = '0;
  logic [NL-1:0] lane_comp_done = '0, lane_comp_error = '0, lane_cal_first_loop = '1;
  logic          rd_ready = 1'b0;
  logic          rd_valid;
  logic [31:0]   rd_data_rise, rd_data_fall;
  logic          comp_done, comp_error, cal_first_loop, overflow;
  logic [15:0]   dbg_lane_level;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  ddr2_rd_data_lanes dut (
    .clk                 (clk),
    .reset               (reset),
    .flush               (flush),
    .read_data_rise      (read_data_rise),
    .read_data_fall      (read_data_fall),
    .lane_rise_en        (lane_rise_en),
    .lane_fall_en        (lane_fall_en),
    .lane_first_rising   (lane_first_rising),
    .lane_comp_done      (lane_comp_done),
    .lane_comp_error     (lane_comp_error),
    .lane_cal_first_loop (lane_cal_first_loop),
    .rd_ready            (rd_ready),
    .rd_valid            (rd_valid),
    .rd_data_rise        (rd_data_rise),
    .rd_data_fall        (rd_data_fall),
    .comp_done           (comp_done),
    .comp_error          (comp_error),
    .cal_first_loop      (cal_first_loop),
    .overflow            (overflow),
    .dbg_lane_level      (dbg_lane_level)
  );

  always #5 clk = ~clk;

  // Reference model: each lane is a queue of paired {rise,fall} entries.
  lane_entry_t mq [NL][$];
  logic        m_staged_v [NL];
  logic [W-1:0] m_staged [NL];
  logic        m_overflow, m_done, m_err, m_cfl;
  logic [NL-1:0] m_lcfl;
  logic        m_pop, m_push;
  lane_entry_t m_ent;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NL; i++) begin
        mq[i].delete();
        m_staged_v[i] = 1'b0;
        m_staged[i]   = '0;
      end
      m_overflow = 1'b0; m_done = 1'b0; m_err = 1'b0; m_cfl = 1'b1; m_lcfl = '1;
    end else begin
      m_pop = rd_ready;
      for (int i = 0; i < NL; i++) if (mq[i].size() == 0) m_pop = 1'b0;
      m_cfl  = !((m_lcfl != lane_cal_first_loop) && (lane_cal_first_loop != 4'hF));
      m_lcfl = lane_cal_first_loop;
      m_done = (lane_comp_done == 4'hF);
      m_err  = m_err || (lane_comp_error != 0);
      if (flush) begin
        for (int i = 0; i < NL; i++) begin
          mq[i].delete();
          m_staged_v[i] = 1'b0;
        end
        m_overflow = 1'b0;
      end else begin
        for (int i = 0; i < NL; i++) begin
          m_push = 1'b0;
          m_ent.fall = read_data_fall[i*W +: W];
          if (!lane_first_rising[i]) begin
            m_staged_v[i] = 1'b0;
            m_push     = lane_rise_en[i];
            m_ent.rise = read_data_rise[i*W +: W];
          end else begin
            m_ent.rise = m_staged[i];
            if (lane_fall_en[i] && m_staged_v[i]) begin
              m_push = 1'b1;
              m_staged_v[i] = 1'b0;
            end
            if (lane_rise_en[i]) begin
              m_staged[i]   = read_data_rise[i*W +: W];
              m_staged_v[i] = 1'b1;
            end
          end
          if (m_pop) void'(mq[i].pop_front());
          if (m_push) begin
            if (mq[i].size() < D) mq[i].push_back(m_ent);
            else m_overflow = 1'b1;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Every cycle, compare all outputs with what the model says they must be.
  always @(negedge clk) begin
    logic        e_valid;
    logic [31:0] e_rise, e_fall;
    logic [15:0] e_lvl;
    if (cmp_en) begin
      e_valid = 1'b1;
      e_rise = '0; e_fall = '0; e_lvl = '0;
      for (int i = 0; i < NL; i++) begin
        if (mq[i].size() == 0) e_valid = 1'b0;
        e_lvl[i*LB +: LB] = LB'(mq[i].size());
      end
      if (e_valid) begin
        for (int i = 0; i < NL; i++) begin
          e_rise[i*W +: W] = mq[i][0].rise;
          e_fall[i*W +: W] = mq[i][0].fall;
        end
      end
      checkOutput("cyc_valid", 64'(rd_valid), 64'(e_valid));
      checkOutput("cyc_rise", 64'(rd_data_rise), 64'(e_rise));
      checkOutput("cyc_fall", 64'(rd_data_fall), 64'(e_fall));
      checkOutput("cyc_level", 64'(dbg_lane_level), 64'(e_lvl));
      checkOutput("cyc_overflow", 64'(overflow), 64'(m_overflow));
      checkOutput("cyc_cal", 64'({comp_done, comp_error, cal_first_loop}), 64'({m_done, m_err, m_cfl}));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of lane inputs, then land just after the capturing edge.
  task automatic applyStimulus(input logic [NL-1:0] re, input logic [NL-1:0] fe,
                               input logic [NL-1:0] fr, input logic [31:0] r,
                               input logic [31:0] f, input logic rdy, input logic fl);
    lane_rise_en      = re;
    lane_fall_en      = fe;
    lane_first_rising = fr;
    read_data_rise    = r;
    read_data_fall    = f;
    rd_ready          = rdy;
    flush             = fl;
    tick();
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk);
    cmp_en = 1'b1;
    #1 reset = 1'b1;
    checkOutput("rst_valid", 64'(rd_valid), 64'd0);
    checkOutput("rst_cfl", 64'(cal_first_loop), 64'd1);

    // Aligned push of all lanes, then pop
    applyStimulus(4'hF, 4'h0, 4'h0, 32'h0403_0201, 32'h0807_0605, 1'b0, 1'b0);
    checkOutput("t1_valid", 64'(rd_valid), 64'd1);
    checkOutput("t1_rise", 64'(rd_data_rise), 64'h0403_0201);
    checkOutput("t1_fall", 64'(rd_data_fall), 64'h0807_0605);
    applyStimulus(4'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("t1_popped", 64'(rd_valid), 64'd0);

    // Lane skew: lanes 0-1 first, lanes 2-3 two cycles later
    applyStimulus(4'b0011, 4'h0, 4'h0, 32'h0000_2211, 32'h0000_6655, 1'b0, 1'b0);
    checkOutput("t2_valid_t1", 64'(rd_valid), 64'd0);
    applyStimulus(4'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("t2_valid_t2", 64'(rd_valid), 64'd0);
    applyStimulus(4'b1100, 4'h0, 4'h0, 32'h4433_0000, 32'h8877_0000, 1'b0, 1'b0);
    checkOutput("t2_valid_t3", 64'(rd_valid), 64'd1);
    checkOutput("t2_rise", 64'(rd_data_rise), 64'h4433_2211);
    checkOutput("t2_fall", 64'(rd_data_fall), 64'h8877_6655);
    applyStimulus(4'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);

    // first_rising on lane 1: rise then fall, then an orphan fall
    applyStimulus(4'b0010, 4'h0, 4'b0010, 32'h0000_AA00, 32'h0, 1'b0, 1'b0);
    checkOutput("t3_staged_lvl", 64'(dbg_lane_level[7:4]), 64'd0);
    applyStimulus(4'h0, 4'b0010, 4'b0010, 32'h0, 32'h0000_5500, 1'b0, 1'b0);
    checkOutput("t3_paired_lvl", 64'(dbg_lane_level[7:4]), 64'd1);
    applyStimulus(4'h0, 4'b0010, 4'b0010, 32'h0, 32'h0000_EE00, 1'b0, 1'b0);
    checkOutput("t3_orphan_lvl", 64'(dbg_lane_level[7:4]), 64'd1);
    applyStimulus(4'b1101, 4'h0, 4'b0010, 32'h0C0B_000A, 32'h0F0E_000D, 1'b0, 1'b0);
    checkOutput("t3_rise", 64'(rd_data_rise), 64'h0C0B_AA0A);
    checkOutput("t3_fall", 64'(rd_data_fall), 64'h0F0E_550D);
    applyStimulus(4'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Overflow: nine pushes with no pops, drain four, then flush
    for (int i = 0; i < 9; i++) begin
      applyStimulus(4'hF, 4'h0, 4'h0, {4{8'(i)}}, {4{8'(i + 8'h80)}}, 1'b0, 1'b0);
      if (i == 7) checkOutput("t4_no_ovf_at_8", 64'(overflow), 64'd0);
    end
    checkOutput("t4_levels", 64'(dbg_lane_level), 64'h8888);
    checkOutput("t4_overflow", 64'(overflow), 64'd1);
    for (int k = 0; k < 4; k++) begin
      checkOutput("t4_order", 64'(rd_data_rise), 64'({4{8'(k)}}));
      applyStimulus(4'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    applyStimulus(4'hF, 4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    checkOutput("t4_flush_lvl", 64'(dbg_lane_level), 64'h0);
    checkOutput("t4_flush_ovf", 64'(overflow), 64'd0);

    // Full lanes with simultaneous push and pop
    for (int i = 0; i < 8; i++)
      applyStimulus(4'hF, 4'h0, 4'h0, {4{8'(8'h10 + i)}}, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checkOutput("t5_order", 64'(rd_data_rise), 64'({4{8'(8'h10 + k)}}));
      applyStimulus(4'hF, 4'h0, 4'h0, {4{8'(8'h20 + k)}}, 32'h0, 1'b1, 1'b0);
      checkOutput("t5_level", 64'(dbg_lane_level), 64'h8888);
    end
    checkOutput("t5_no_ovf", 64'(overflow), 64'd0);
    applyStimulus(4'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Calibration flags
    lane_cal_first_loop = 4'b1101;
    tick();
    checkOutput("t6_cfl_low", 64'(cal_first_loop), 64'd0);
    tick();
    checkOutput("t6_cfl_back", 64'(cal_first_loop), 64'd1);
    lane_comp_done = 4'hF;
    tick();
    checkOutput("t6_done", 64'(comp_done), 64'd1);
    lane_comp_error = 4'b0100;
    tick();
    lane_comp_error = 4'b0000;
    tick();
    checkOutput("t6_err_sticky", 64'(comp_error), 64'd1);
    lane_cal_first_loop = 4'hF;
    tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [NL-1:0] re, fe, fr;
      re = 4'($urandom) | 4'($urandom);
      fe = 4'($urandom) | 4'($urandom);
      fr = ($urandom_range(0, 19) == 0) ? 4'($urandom) : lane_first_rising;
      if ($urandom_range(0, 29) == 0) lane_cal_first_loop = 4'($urandom) | 4'($urandom);
      if ($urandom_range(0, 29) == 0) lane_comp_done = 4'($urandom) | 4'($urandom);
      lane_comp_error = ($urandom_range(0, 199) == 0) ? 4'($urandom) : 4'h0;
      applyStimulus(re, fe, fr, $urandom, $urandom, ($urandom_range(0, 9) < 6),
                    ($urandom_range(0, 99) == 0));
    end

    // Reset in the middle of a burst clears everything asynchronously
    for (int i = 0; i < 3; i++)
      applyStimulus(4'hF, 4'h0, 4'h0, $urandom, $urandom, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    checkOutput("rst_mid_valid", 64'(rd_valid), 64'd0);
    checkOutput("rst_mid_data", 64'(rd_data_rise), 64'd0);
    checkOutput("rst_mid_lvl", 64'(dbg_lane_level), 64'd0);
    checkOutput("rst_mid_flags", 64'({overflow, comp_done, comp_error, cal_first_loop}), 64'b0001);
    tick();
    reset = 1'b1;
    repeat (3) tick();

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
